dec_locate_sequencer: RTL and testbench

- Controller that sequences the DEC bit-serial error-location datapath for one received codeword.
- Accepts a codeword plus syndrome summary flags (syndrome-zero, double-error-detected) from the syndrome stage.
- Walks a bit index across all codeword positions, driving the external error-locator slice one position per cycle, and flips every bit the locator flags.
- Returns the corrected codeword with a status code via valid/ready; sits between the syndrome generator and the data-out stage.

---
 rtl/dec_pkg.sv | 17 +
 rtl/dec_status_classify.sv | 19 +
 rtl/dec_locate_sequencer.sv | 149 ++++++++++++++
 tb/tb_dec_locate_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and constants for the DEC error-location sequencer.
package dec_pkg;

    localparam int DEF_N_BITS = 44;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_SINGLE = 2'b01;
    localparam logic [1:0] ST_DOUBLE = 2'b10;
    localparam logic [1:0] ST_UNCORR = 2'b11;

endpackage

// File: rtl/dec_status_classify.sv
// Maps the double-error flag and final locator hit count to a result status.
module dec_status_classify
    import dec_pkg::*;
(
    input  logic       ded_i,
    input  logic [1:0] cnt_i,
    output logic [1:0] status_o
);

    always_comb begin
        status_o = ST_UNCORR;
        if (!ded_i && cnt_i == 2'd1) begin
            status_o = ST_SINGLE;
        end else if (ded_i && cnt_i == 2'd2) begin
            status_o = ST_DOUBLE;
        end
    end

endmodule

// File: rtl/dec_locate_sequencer.sv
// Sequences the bit-serial DEC error locator over one codeword and flips flagged bits.
// Optional build macro DEC_EARLY_EXIT_EN: stop scanning once the expected hit count is reached.
module dec_locate_sequencer
    import dec_pkg::*;
#(
    parameter int N_BITS = DEF_N_BITS,
    parameter int IDX_W  = $clog2(N_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in_cw,
    input  logic              in_syn_zero,
    input  logic              in_ded,
    output logic              loc_en,
    output logic [IDX_W-1:0]  loc_idx,
    input  logic              loc_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_cw,
    output logic [1:0]        out_status,
    output logic [1:0]        out_err_cnt
);

    state_t            state_q, state_d;
    logic [N_BITS-1:0] work_q, work_d;
    logic [N_BITS-1:0] orig_q, orig_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        status_q, status_d;
    logic              ded_q, ded_d;

    logic              accept;
    logic [1:0]        cnt_hit;
    logic [1:0]        cnt_scan;
    logic [1:0]        cls_status;
    logic              last_pos;
    logic              scan_end;
    logic [N_BITS-1:0] work_flip;

    assign in_ready = (state_q == S_IDLE) & ~rst;
    assign accept   = in_valid & in_ready;

    assign cnt_hit  = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
    assign cnt_scan = loc_err ? cnt_hit : cnt_q;
    assign last_pos = (idx_q == IDX_W'(N_BITS - 1));

`ifdef DEC_EARLY_EXIT_EN
    assign scan_end = last_pos | (loc_err & (cnt_scan == (ded_q ? 2'd2 : 2'd1)));
`else
    assign scan_end = last_pos;
`endif

    // Status is classified from the count including this cycle's hit.
    dec_status_classify u_classify (
        .ded_i    (ded_q),
        .cnt_i    (cnt_scan),
        .status_o (cls_status)
    );

    always_comb begin
        work_flip         = work_q;
        work_flip[idx_q]  = ~work_q[idx_q];
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        orig_d    = orig_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        ded_d     = ded_q;
        loc_en    = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    work_d = in_cw;
                    orig_d = in_cw;
                    ded_d  = in_ded;
                    cnt_d  = 2'd0;
                    idx_d  = '0;
                    if (in_syn_zero) begin
                        status_d = ST_CLEAN;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                loc_en = 1'b1;
                cnt_d  = cnt_scan;
                if (loc_err) begin
                    work_d = work_flip;
                end
                if (scan_end) begin
                    state_d  = S_DONE;
                    idx_d    = '0;
                    status_d = cls_status;
                    // An uncorrectable word is returned exactly as received.
                    if (cls_status == ST_UNCORR) begin
                        work_d = orig_q;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            orig_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= 2'd0;
            status_q <= ST_CLEAN;
            ded_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            orig_q   <= orig_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            ded_q    <= ded_d;
        end
    end

    assign loc_idx     = idx_q;
    assign out_cw      = work_q;
    assign out_status  = status_q;
    assign out_err_cnt = cnt_q;

endmodule

// File: tb/tb_dec_locate_sequencer.sv
// Directed bench for dec_locate_sequencer with a behavioural result/timing model.
module tb_dec_locate_sequencer;

    localparam int N = 44;
    localparam int W = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_cw = '0;
    logic          in_syn_zero = 1'b0;
    logic          in_ded = 1'b0;
    logic          loc_en;
    logic [W-1:0]  loc_idx;
    logic          loc_err;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_cw;
    logic [1:0]    out_status;
    logic [1:0]    out_err_cnt;

    logic [N-1:0]  loc_flags = '0;
    logic [63:0]   flags64;

    int checks = 0;
    int failures = 0;

    logic [N-1:0]  exp_cw;
    logic [1:0]    exp_status;
    logic [1:0]    exp_cnt;
    logic          exp_sz;
    int            exp_L;

    logic          active = 1'b0;
    int            c = 0;

    logic          seen = 1'b0;
    int            first_c = 0;
    logic [N-1:0]  first_cw = '0;
    logic [1:0]    first_status = '0;
    logic [1:0]    first_cnt = '0;

    always #5 clk = ~clk;

    dec_locate_sequencer #(.N_BITS(N), .IDX_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cw       (in_cw),
        .in_syn_zero (in_syn_zero),
        .in_ded      (in_ded),
        .loc_en      (loc_en),
        .loc_idx     (loc_idx),
        .loc_err     (loc_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_cw      (out_cw),
        .out_status  (out_status),
        .out_err_cnt (out_err_cnt)
    );

    // Locator stand-in: flags chosen positions, and shouts "error" whenever not queried.
    assign flags64 = {20'b0, loc_flags};
    assign loc_err = loc_en ? flags64[loc_idx] : 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [N-1:0] cw, input logic sz, input logic ded,
                         input logic [N-1:0] flg);
        int hits;
        logic [N-1:0] w;
`ifdef DEC_EARLY_EXIT_EN
        int tgt;
        tgt = ded ? 2 : 1;
`endif
        hits   = 0;
        w      = cw;
        exp_sz = sz;
        exp_L  = N + 1;
        if (sz) begin
            exp_cw = cw; exp_status = 2'd0; exp_cnt = 2'd0; exp_L = 1;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (flg[i]) begin
                hits++;
                w[i] = ~w[i];
`ifdef DEC_EARLY_EXIT_EN
                if (hits == tgt) begin
                    exp_L = i + 2;
                    break;
                end
`endif
            end
        end
        exp_cnt = (hits > 3) ? 2'd3 : 2'(hits);
        if (!ded && exp_cnt == 2'd1)     exp_status = 2'd1;
        else if (ded && exp_cnt == 2'd2) exp_status = 2'd2;
        else                             exp_status = 2'd3;
        exp_cw = (exp_status == 2'd3) ? cw : w;
    endtask

    // Transaction tracker: cycle c=1 is the first cycle after the accepting edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
        end else if (!active && in_valid && in_ready) begin
            active <= 1'b1;
            c      <= 1;
        end else if (active) begin
            if (out_valid && out_ready) active <= 1'b0;
            else c <= c + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_loc_en", loc_en, 0);
            chk("rst_loc_idx", loc_idx, 0);
            chk("rst_out_cw", out_cw, 0);
            chk("rst_status", out_status, 0);
            chk("rst_cnt", out_err_cnt, 0);
            chk("rst_in_ready", in_ready, 0);
        end else if (!active) begin
            chk("idle_out_valid", out_valid, 0);
            chk("idle_loc_en", loc_en, 0);
            chk("idle_in_ready", in_ready, 1);
        end else begin
            if (c == 1) seen = 1'b0;
            chk("out_valid", out_valid, (c >= exp_L));
            chk("loc_en", loc_en, (!exp_sz && c < exp_L));
            if (!exp_sz && c < exp_L) chk("loc_idx", loc_idx, c - 1);
            if (out_valid) begin
                chk("out_cw", out_cw, exp_cw);
                chk("out_status", out_status, exp_status);
                chk("out_err_cnt", out_err_cnt, exp_cnt);
                chk("busy_in_ready", in_ready, 0);
                if (!seen) begin
                    seen = 1'b1;
                    first_c = c;
                    first_cw = out_cw;
                    first_status = out_status;
                    first_cnt = out_err_cnt;
                end
            end
        end
    end

    task automatic start(input logic [N-1:0] cw, input logic sz, input logic ded,
                         input logic [N-1:0] flg);
        model(cw, sz, ded, flg);
        @(negedge clk);
        loc_flags   = flg;
        in_cw       = cw;
        in_syn_zero = sz;
        in_ded      = ded;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accepted", active, 1);
    endtask

    task automatic finish_txn();
        int n;
        n = 0;
        while (active && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", active, 0);
    endtask

    function automatic logic [N-1:0] bits(input int a, input int b, input int d, input int e);
        logic [N-1:0] f;
        f = '0;
        if (a >= 0) f[a] = 1'b1;
        if (b >= 0) f[b] = 1'b1;
        if (d >= 0) f[d] = 1'b1;
        if (e >= 0) f[e] = 1'b1;
        return f;
    endfunction

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Clean word; locator flags must be ignored
        start(44'h0AB_CDEF_1234, 1'b1, 1'b0, bits(0, 7, -1, -1));
        finish_txn();
        chk("clean_lat", first_c, 1);
        chk("clean_cw", first_cw, 44'h0AB_CDEF_1234);
        chk("clean_status", first_status, 2'b00);

        // Single error at bit 5
        start(44'h0AB_CDEF_1234, 1'b0, 1'b0, bits(5, -1, -1, -1));
        finish_txn();
        chk("single_cw", first_cw, 44'h0AB_CDEF_1214);
        chk("single_status", first_status, 2'b01);
        chk("single_cnt", first_cnt, 2'd1);
`ifdef DEC_EARLY_EXIT_EN
        chk("single_lat", first_c, 7);
`else
        chk("single_lat", first_c, 45);
`endif

        // Double error at bits 3 and 43 (last scan position)
        start(44'h123_4567_89AB, 1'b0, 1'b1, bits(3, 43, -1, -1));
        finish_txn();
        chk("double_cw", first_cw, 44'h923_4567_89A3);
        chk("double_status", first_status, 2'b10);
        chk("double_cnt", first_cnt, 2'd2);
        chk("double_lat", first_c, 45);

        // Syndrome nonzero but locator never fires
        start(44'hFED_CBA9_8765, 1'b0, 1'b0, '0);
        finish_txn();
        chk("nohit_cw", first_cw, 44'hFED_CBA9_8765);
        chk("nohit_status", first_status, 2'b11);
        chk("nohit_cnt", first_cnt, 2'd0);

        // Three hits with ded=0, then four hits with ded=1 (count saturates)
        start(44'h555_5555_5555, 1'b0, 1'b0, bits(2, 9, 30, -1));
        finish_txn();
`ifndef DEC_EARLY_EXIT_EN
        chk("triple_cw", first_cw, 44'h555_5555_5555);
        chk("triple_status", first_status, 2'b11);
        chk("triple_cnt", first_cnt, 2'd3);
`endif
        start(44'h0F0_F0F0_F0F0, 1'b0, 1'b1, bits(1, 10, 20, 40));
        finish_txn();
`ifndef DEC_EARLY_EXIT_EN
        chk("quad_status", first_status, 2'b11);
        chk("quad_cnt", first_cnt, 2'd3);
`endif

        // Backpressure in DONE with in_valid pulses that must be ignored
        out_ready = 1'b0;
        start(44'h3C3_C3C3_C3C3, 1'b0, 1'b0, bits(17, -1, -1, -1));
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reached_done", out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            in_valid = (i % 2 == 0);
            in_cw    = 44'h111_1111_1111 + 44'(i);
        end
        @(negedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_txn();
        chk("bp_cw", first_cw, 44'h3C3_C3C3_C3C3 ^ (44'h1 << 17));

        // Reset in the middle of a scan
        start(44'h0AB_CDEF_1234, 1'b0, 1'b0, bits(30, -1, -1, -1));
        n = 0;
        while (!(loc_en && loc_idx == 6'd20) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_scan_idx", loc_idx, 20);
        #2 rst = 1'b1;
        #1;
        chk("rst_now_loc_en", loc_en, 0);
        chk("rst_now_out_valid", out_valid, 0);
        chk("rst_now_cw", out_cw, 0);
        chk("rst_now_idx", loc_idx, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        start(44'h000_0000_0001, 1'b0, 1'b0, bits(0, -1, -1, -1));
        finish_txn();
        chk("post_rst_cw", first_cw, 44'h0);
        chk("post_rst_status", first_status, 2'b01);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
